// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the data-memory arbiter.
//   state_e : sequencer states (IDLE, ACCESS, RESP)
//   owner_e : which requester owns the current transaction
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } owner_e;

  localparam logic [31:0] DefaultBaseAddr = 32'h1000_1000;
  localparam int unsigned DefaultDepth    = 16;

endpackage

// File: rtl/dmem_addr_decode.sv
// Byte address to word index translation for the data segment.
//   addr : byte address
//   idx  : (addr - BASE_ADDR) >> 2, truncated to IDX_W bits (wraps modulo DEPTH)
//   bad  : address outside the segment or not word aligned
//          (port present only when DMEM_ARB_ADDR_CHECK_EN is defined)
module dmem_addr_decode #(
  parameter logic [31:0] BASE_ADDR = dmem_arb_pkg::DefaultBaseAddr,
  parameter int unsigned DEPTH     = dmem_arb_pkg::DefaultDepth,
  parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic [31:0]      addr,
`ifdef DMEM_ARB_ADDR_CHECK_EN
  output logic             bad,
`endif
  output logic [IDX_W-1:0] idx
);

  // 32-bit unsigned difference; the cast keeps only the low index bits.
  assign idx = IDX_W'((addr - BASE_ADDR) >> 2);

`ifdef DMEM_ARB_ADDR_CHECK_EN
  assign bad = (addr < BASE_ADDR) ||
               ((addr - BASE_ADDR) >= 32'(4 * DEPTH)) ||
               (addr[1:0] != 2'b00);
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port data memory.
// Round-robin between the CPU and debug ports, one transaction at a time:
// IDLE (grant + latch) -> ACCESS (drive memory one cycle) -> RESP (ack pulse).
//   cpu_* / dbg_* : requester ports (req held until ack, ack is a one-cycle pulse)
//   mem_*         : memory array interface, strobes only during ACCESS
//   err           : pulses with ack on a rejected access
// Optional macro DMEM_ARB_ADDR_CHECK_EN enables address range/alignment rejection;
// without it the index wraps modulo DEPTH and err is tied low.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_ack,
  output logic [31:0]      cpu_rdata,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [31:0]      dbg_addr,
  input  logic [31:0]      dbg_wdata,
  output logic             dbg_ack,
  output logic [31:0]      dbg_rdata,
  output logic [IDX_W-1:0] mem_idx,
  output logic [31:0]      mem_wdata,
  output logic             mem_we,
  output logic             mem_re,
  input  logic [31:0]      mem_rdata,
  output logic             err
);

  state_e      state_q, state_d;
  owner_e      last_q, last_d;
  owner_e      owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dbg_ack_q, dbg_ack_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;

  logic             grant_dbg;
  logic [31:0]      rd_word;
  logic [IDX_W-1:0] dec_idx;
  logic             dec_bad;

  // Decode from the latched address so ACCESS sees stable fields even if req drops.
`ifdef DMEM_ARB_ADDR_CHECK_EN
  dmem_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_decode (
    .addr (addr_q),
    .bad  (dec_bad),
    .idx  (dec_idx)
  );
`else
  dmem_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_decode (
    .addr (addr_q),
    .idx  (dec_idx)
  );
  assign dec_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = '0;
    dbg_rdata_d = '0;
    // Debug wins when alone, or on a tie when the CPU was granted last.
    grant_dbg   = dbg_req && (!cpu_req || (last_q == OWN_CPU));
    rd_word     = (!we_q && !dec_bad) ? mem_rdata : '0;

    unique case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d = grant_dbg ? OWN_DBG : OWN_CPU;
          last_d  = grant_dbg ? OWN_DBG : OWN_CPU;
          we_d    = grant_dbg ? dbg_we : cpu_we;
          addr_d  = grant_dbg ? dbg_addr : cpu_addr;
          wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cpu_ack_d   = (owner_q == OWN_CPU);
        dbg_ack_d   = (owner_q == OWN_DBG);
        cpu_rdata_d = (owner_q == OWN_CPU) ? rd_word : '0;
        dbg_rdata_d = (owner_q == OWN_DBG) ? rd_word : '0;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= OWN_DBG;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

`ifdef DMEM_ARB_ADDR_CHECK_EN
  logic err_q, err_d;

  // ACCESS always moves to RESP, so err lines up with the ack pulse.
  always_comb err_d = (state_q == ACCESS) && dec_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Memory side is gated by state so an asynchronous reset clears it at once.
  assign mem_idx   = (state_q == ACCESS) ? dec_idx : '0;
  assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
  assign mem_we    = (state_q == ACCESS) && we_q && !dec_bad;
  assign mem_re    = (state_q == ACCESS) && !we_q && !dec_bad;

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transactions push expected responses
// and memory accesses into queues; monitors on the falling edge pop and compare.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_ack, dbg_ack, mem_we, mem_re, err;
  logic [31:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [3:0]  mem_idx;

  logic [31:0] mem [16];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    bit          is_dbg;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [3:0]  idx;
    logic [31:0] wdata;
  } acc_t;

  rsp_t rsp_q[$];
  acc_t acc_q[$];

  dmem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_idx   (mem_idx),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory model: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_idx];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4]  = 32'h1234_5678;
    mem[15] = 32'hA5A5_0F0F;
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_idx] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void exp_rsp(bit d, logic [31:0] r, logic e, int c);
    rsp_t t;
    t.is_dbg = d; t.rdata = r; t.err = e; t.cyc = c;
    rsp_q.push_back(t);
  endfunction

  function automatic void exp_acc(logic w, logic [3:0] i, logic [31:0] wd);
    acc_t t;
    t.we = w; t.idx = i; t.wdata = wd;
    acc_q.push_back(t);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " cpu_ack"},   {31'b0, cpu_ack}, 32'h0);
    chk({tag, " dbg_ack"},   {31'b0, dbg_ack}, 32'h0);
    chk({tag, " err"},       {31'b0, err},     32'h0);
    chk({tag, " mem_we"},    {31'b0, mem_we},  32'h0);
    chk({tag, " mem_re"},    {31'b0, mem_re},  32'h0);
    chk({tag, " cpu_rdata"}, cpu_rdata,        32'h0);
    chk({tag, " dbg_rdata"}, dbg_rdata,        32'h0);
    chk({tag, " mem_idx"},   {28'b0, mem_idx}, 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata,        32'h0);
  endtask

  // Response monitor.
  initial forever begin
    @(negedge clk);
    if (cpu_ack || dbg_ack) begin
      if (rsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: cpu_ack %b dbg_ack %b, none expected (cycle %0d)",
                 cpu_ack, dbg_ack, cyc);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        chk("cpu_ack",   {31'b0, cpu_ack}, {31'b0, !e.is_dbg});
        chk("dbg_ack",   {31'b0, dbg_ack}, {31'b0, e.is_dbg});
        chk("cpu_rdata", cpu_rdata, e.is_dbg ? 32'h0 : e.rdata);
        chk("dbg_rdata", dbg_rdata, e.is_dbg ? e.rdata : 32'h0);
        chk("err",       {31'b0, err}, {31'b0, e.err});
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Memory access monitor: each strobe cycle must match one expected access.
  initial forever begin
    @(negedge clk);
    if (mem_we || mem_re) begin
      if (acc_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_access: we %b re %b idx %0d, none expected (cycle %0d)",
                 mem_we, mem_re, mem_idx, cyc);
      end else begin
        acc_t a;
        a = acc_q.pop_front();
        chk("mem_we",  {31'b0, mem_we}, {31'b0, a.we});
        chk("mem_re",  {31'b0, mem_re}, {31'b0, !a.we});
        chk("mem_idx", {28'b0, mem_idx}, {28'b0, a.idx});
        if (a.we) chk("mem_wdata", mem_wdata, a.wdata);
      end
    end
  end

  initial begin
    int k;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

    tick(2);
    chk_zero("reset");
    rst_n = 1'b1;
    tick(1);

    // Tie out of reset: CPU first, debug three cycles later.
    k = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000_1010;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h1000_1004; dbg_wdata = 32'h3333_4444;
    exp_rsp(1'b0, 32'h1234_5678, 1'b0, k + 2);
    exp_acc(1'b0, 4'd4, 32'h0);
    exp_rsp(1'b1, 32'h0, 1'b0, k + 5);
    exp_acc(1'b1, 4'd1, 32'h3333_4444);
    tick(3);
    cpu_req = 1'b0;
    tick(3);
    dbg_req = 1'b0; dbg_we = 1'b0;

    // CPU write then read back of word 0.
    k = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1000_1000; cpu_wdata = 32'h1111_2222;
    exp_rsp(1'b0, 32'h0, 1'b0, k + 2);
    exp_acc(1'b1, 4'd0, 32'h1111_2222);
    tick(3);
    k = cyc;
    cpu_we = 1'b0;
    exp_rsp(1'b0, 32'h1111_2222, 1'b0, k + 2);
    exp_acc(1'b0, 4'd0, 32'h0);
    tick(3);
    cpu_req = 1'b0;

    // Debug drops req right after being sampled; transaction still completes.
    k = cyc;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1000_1004;
    exp_rsp(1'b1, 32'h3333_4444, 1'b0, k + 2);
    exp_acc(1'b0, 4'd1, 32'h0);
    tick(1);
    dbg_req = 1'b0;
    tick(2);

    // Both hold req for six transactions: strict alternation starting with CPU.
    k = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000_1000;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1000_1010;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        exp_rsp(1'b0, 32'h1111_2222, 1'b0, k + 2 + 3 * i);
        exp_acc(1'b0, 4'd0, 32'h0);
      end else begin
        exp_rsp(1'b1, 32'h1234_5678, 1'b0, k + 2 + 3 * i);
        exp_acc(1'b0, 4'd4, 32'h0);
      end
    end
    tick(18);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick(1);

    // Address boundaries: last word, one past the end, below base, misaligned.
    k = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000_103C;
    exp_rsp(1'b0, 32'hA5A5_0F0F, 1'b0, k + 2);
    exp_acc(1'b0, 4'd15, 32'h0);
    tick(3);
    k = cyc;
    cpu_addr = 32'h1000_1040;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    exp_rsp(1'b0, 32'h0, 1'b1, k + 2);
`else
    exp_rsp(1'b0, 32'h1111_2222, 1'b0, k + 2);
    exp_acc(1'b0, 4'd0, 32'h0);
`endif
    tick(3);
    cpu_req = 1'b0;
    k = cyc;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h1000_0FFC;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    exp_rsp(1'b1, 32'h0, 1'b1, k + 2);
`else
    exp_rsp(1'b1, 32'hA5A5_0F0F, 1'b0, k + 2);
    exp_acc(1'b0, 4'd15, 32'h0);
`endif
    tick(3);
    k = cyc;
    dbg_we = 1'b1; dbg_addr = 32'h1000_1001; dbg_wdata = 32'hDEAD_BEEF;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    exp_rsp(1'b1, 32'h0, 1'b1, k + 2);
`else
    exp_rsp(1'b1, 32'h0, 1'b0, k + 2);
    exp_acc(1'b1, 4'd0, 32'hDEAD_BEEF);
`endif
    tick(3);
    dbg_req = 1'b0; dbg_we = 1'b0;

    // Reset during the ACCESS cycle of a debug write: no ack, outputs clear at once.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h1000_1008; dbg_wdata = 32'h5555_AAAA;
    tick(1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    dbg_req = 1'b0; dbg_we = 1'b0;
    tick(2);

    // Release reset with a CPU read raised in the same cycle.
    k = cyc;
    rst_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1000_1004;
    exp_rsp(1'b0, 32'h3333_4444, 1'b0, k + 2);
    exp_acc(1'b0, 4'd1, 32'h0);
    tick(3);
    cpu_req = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (rsp_q.size() != 0 || acc_q.size() != 0) tick(1);
    end
    chk("pending_responses", 32'(rsp_q.size()), 32'h0);
    chk("pending_accesses",  32'(acc_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
